shift_issue_stage: RTL and testbench

- Operand-issue stage directly upstream of the combinational 32-bit shifter (data0_i = value, data1_i = 5-bit amount, data2_i = direction: 1 left logical, 0 right arithmetic).
- Decodes R-type shift funct codes and selects immediate shamt or rs[4:0].
- Buffers operands in a 2-entry skid buffer with valid/ready on both sides.
- Supplies a post-shift AND mask so the consumer builds srl/srlv from the arithmetic-only right shift.

---
 rtl/shift_issue_stage.sv | 138 +++++++++++++
 tb/tb_shift_issue_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// Operand-issue stage ahead of the 32-bit shifter: decodes shift functs, buffers in a 2-entry skid buffer.
// Optional statistics counters are enabled with `define SHIFT_ISSUE_STATS_EN.
module shift_issue_stage #(
  parameter int STAT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [5:0]  funct_i,
  input  logic [4:0]  shamt_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] sh_data_o,
  output logic [4:0]  sh_amt_o,
  output logic        sh_dir_o,
  output logic [31:0] sh_keep_o,
  output logic [4:0]  rd_addr_o,
  output logic        illegal_o
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [STAT_W-1:0] shift_cnt_o,
  output logic [STAT_W-1:0] illegal_cnt_o
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  amt;
    logic        dir;
    logic [31:0] keep;
    logic [4:0]  rd;
  } entry_t;

  state_t state, state_nxt;
  entry_t head, tail, dec;
  logic   legal, var_amt, dec_dir, logical;
  logic   [4:0] dec_amt;
  logic   accept, push, pop, illegal_q;
  logic   unused_rs;

  assign unused_rs = ^rs_data_i[31:5];

  always_comb begin
    legal   = 1'b1;
    var_amt = 1'b0;
    dec_dir = 1'b0;
    logical = 1'b0;
    case (funct_i)
      6'b000000: dec_dir = 1'b1;
      6'b000010: logical = 1'b1;
      6'b000011: ;
      6'b000100: begin dec_dir = 1'b1; var_amt = 1'b1; end
      6'b000110: begin logical = 1'b1; var_amt = 1'b1; end
      6'b000111: var_amt = 1'b1;
      default:   legal = 1'b0;
    endcase
    dec_amt   = var_amt ? rs_data_i[4:0] : shamt_i;
    dec.data  = rt_data_i;
    dec.amt   = dec_amt;
    dec.dir   = dec_dir;
    // The shifter only does arithmetic right shifts; this mask strips the sign fill for srl/srlv.
    dec.keep  = logical ? (32'hFFFF_FFFF >> dec_amt) : 32'hFFFF_FFFF;
    dec.rd    = rd_addr_i;
  end

  assign in_ready_o = (state != TWO) & ~rst_i;
  assign accept     = in_valid_i & in_ready_o;
  assign push       = accept & legal;
  assign pop        = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE:     if (push && !pop) state_nxt = TWO;
               else if (!push && pop) state_nxt = EMPTY;
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid_o = (state != EMPTY);
    sh_data_o   = out_valid_o ? head.data : 32'd0;
    sh_amt_o    = out_valid_o ? head.amt  : 5'd0;
    sh_dir_o    = out_valid_o & head.dir;
    sh_keep_o   = out_valid_o ? head.keep : 32'd0;
    rd_addr_o   = out_valid_o ? head.rd   : 5'd0;
    illegal_o   = illegal_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head      <= '0;
      tail      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept & ~legal;
      case (state)
        EMPTY: if (push) head <= dec;
        // Simultaneous push and pop in ONE: the new entry replaces the departing head.
        ONE:   if (push && pop) head <= dec;
               else if (push) tail <= dec;
        TWO:   if (pop) head <= tail;
        default: ;
      endcase
    end
  end

`ifdef SHIFT_ISSUE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_cnt_o   <= '0;
      illegal_cnt_o <= '0;
    end else begin
      if (push && !(&shift_cnt_o))
        shift_cnt_o <= shift_cnt_o + STAT_W'(1);
      if (accept && !legal && !(&illegal_cnt_o))
        illegal_cnt_o <= illegal_cnt_o + STAT_W'(1);
    end
  end
`else
  logic [STAT_W-1:0] unused_stat;
  assign unused_stat = '0;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Randomized plus directed bench for shift_issue_stage against a queue-based reference model.
module tb_shift_issue_stage;
  localparam int STAT_W = 16;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sh_data;
  logic [4:0]  sh_amt;
  logic        sh_dir;
  logic [31:0] sh_keep;
  logic [4:0]  rd_out;
  logic        illegal;
`ifdef SHIFT_ISSUE_STATS_EN
  logic [STAT_W-1:0] shift_cnt, illegal_cnt;
`endif

  always #5 clk = ~clk;

  shift_issue_stage #(.STAT_W(STAT_W)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .funct_i(funct), .shamt_i(shamt), .rs_data_i(rs_data), .rt_data_i(rt_data),
    .rd_addr_i(rd_addr), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sh_data_o(sh_data), .sh_amt_o(sh_amt), .sh_dir_o(sh_dir), .sh_keep_o(sh_keep),
    .rd_addr_o(rd_out), .illegal_o(illegal)
`ifdef SHIFT_ISSUE_STATS_EN
    , .shift_cnt_o(shift_cnt), .illegal_cnt_o(illegal_cnt)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  amt;
    logic        dir;
    logic [31:0] keep;
    logic [4:0]  rd;
  } ent_t;

  ent_t q[$];
  bit   exp_ill;
  int   exp_sc, exp_ic;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode by mnemonic: "v" suffix means the amount comes from rs, "srl*" masks off sign fill.
  function automatic bit model_decode(input logic [5:0] f, input logic [4:0] sa,
                                      input logic [31:0] rs, input logic [31:0] rt,
                                      input logic [4:0] rd, output ent_t e);
    string mn;
    case (f)
      6'd0: mn = "sll";   6'd2: mn = "srl";   6'd3: mn = "sra";
      6'd4: mn = "sllv";  6'd6: mn = "srlv";  6'd7: mn = "srav";
      default: mn = "";
    endcase
    e.data = rt;
    e.rd   = rd;
    e.amt  = (mn.len() == 4) ? rs[4:0] : sa;
    e.dir  = (mn.len() > 0) && (mn.substr(0, 1) == "sl");
    for (int i = 0; i < 32; i++)
      e.keep[i] = (mn.len() > 0 && mn.substr(0, 2) == "srl") ? (i < 32 - int'(e.amt)) : 1'b1;
    return mn.len() > 0;
  endfunction

  task automatic compare_all();
    ent_t h;
    h = '{default: '0};
    if (q.size() > 0) h = q[0];
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("sh_data", 64'(sh_data), 64'(h.data));
    check("sh_amt", 64'(sh_amt), 64'(h.amt));
    check("sh_dir", 64'(sh_dir), 64'(h.dir));
    check("sh_keep", 64'(sh_keep), 64'(h.keep));
    check("rd_addr", 64'(rd_out), 64'(h.rd));
    check("illegal", 64'(illegal), 64'(exp_ill));
`ifdef SHIFT_ISSUE_STATS_EN
    check("shift_cnt", 64'(shift_cnt), 64'(exp_sc));
    check("illegal_cnt", 64'(illegal_cnt), 64'(exp_ic));
`endif
  endtask

  // One clock: drive inputs, check ready, advance the model, then check registered outputs.
  task automatic step(input bit r, input bit v, input logic [5:0] f, input logic [4:0] sa,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                      input bit ordy);
    ent_t e;
    bit lg, acc, pp;
    rst = r; in_valid = v; funct = f; shamt = sa; rs_data = rs; rt_data = rt;
    rd_addr = rd; out_ready = ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(!r && q.size() < 2));
    if (r) begin
      q.delete(); exp_ill = 0; exp_sc = 0; exp_ic = 0;
    end else begin
      lg  = model_decode(f, sa, rs, rt, rd, e);
      acc = v && q.size() < 2;
      pp  = ordy && q.size() > 0;
      if (pp) void'(q.pop_front());
      if (acc && lg) q.push_back(e);
      exp_ill = acc && !lg;
      if (acc && lg && exp_sc < STAT_MAX) exp_sc++;
      if (acc && !lg && exp_ic < STAT_MAX) exp_ic++;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  logic [5:0] funct_tab [8];
  logic [31:0] and_res;

  initial begin
    funct_tab = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'h20, 6'h2a};
    @(posedge clk);
    #1;
    // Reset held with an offer pending.
    repeat (3) step(1, 1, 6'd0, 5'd1, 32'h1, 32'h5, 5'd3, 1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    step(0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1);
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // Illegal funct (add) while empty.
    step(0, 1, 6'h20, 5'd2, 32'h0, 32'h1234, 5'd4, 1);
    check("ill_pulse", 64'(illegal), 64'd1);
    check("ill_no_valid", 64'(out_valid), 64'd0);
`ifdef SHIFT_ISSUE_STATS_EN
    check("ill_cnt_lit", 64'(illegal_cnt), 64'd1);
    check("shift_cnt_lit", 64'(shift_cnt), 64'd0);
`endif
    step(0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1);
    check("ill_one_cycle", 64'(illegal), 64'd0);

    // srl decode.
    step(0, 1, 6'b000010, 5'd4, 32'h0, 32'hF000_0000, 5'd9, 1);
    check("srl_keep_lit", 64'(sh_keep), 64'h0FFF_FFFF);
    check("srl_amt_lit", 64'(sh_amt), 64'd4);
    check("srl_rd_lit", 64'(rd_out), 64'd9);
    and_res = 32'($signed(sh_data) >>> sh_amt) & sh_keep;
    check("srl_and_lit", 64'(and_res), 64'h0F00_0000);

    // sllv, popping the srl entry in the same cycle.
    step(0, 1, 6'b000100, 5'd7, 32'hFFFF_FFE3, 32'h1, 5'd2, 1);
    check("sllv_amt_lit", 64'(sh_amt), 64'd3);
    check("sllv_dir_lit", 64'(sh_dir), 64'd1);
    check("sllv_keep_lit", 64'(sh_keep), 64'hFFFF_FFFF);
    step(0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1);

    // Backpressure: A, B stalled, then drained in order.
    step(0, 1, 6'd3, 5'd5, 32'h0, 32'hAAAA_0001, 5'd10, 0);
    step(0, 1, 6'd0, 5'd6, 32'h0, 32'hBBBB_0002, 5'd11, 0);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    step(0, 1, 6'd0, 5'd1, 32'h0, 32'hCCCC_0003, 5'd12, 0);
    check("bp_hold_A", 64'(sh_data), 64'hAAAA_0001);
    step(0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1);
    check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    check("bp_head_B", 64'(sh_data), 64'hBBBB_0002);
    step(0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1);

    // Push+pop in ONE, then reset with two entries buffered.
    step(0, 1, 6'd7, 5'd0, 32'h2, 32'hAAAA_1111, 5'd0, 0);
    step(0, 1, 6'd6, 5'd0, 32'h8, 32'hCCCC_2222, 5'd13, 1);
    check("pp_head_C", 64'(sh_data), 64'hCCCC_2222);
    step(0, 1, 6'd2, 5'd31, 32'h0, 32'hDDDD_3333, 5'd14, 0);
    step(1, 0, 6'd0, 5'd0, 32'h0, 32'h0, 5'd0, 0);
    check("rst_flush", 64'(out_valid), 64'd0);
    step(0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 5'd0, 0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) == 0, $urandom_range(9) < 7, funct_tab[$urandom_range(7)],
           5'($urandom), $urandom, $urandom, 5'($urandom), $urandom_range(9) < 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
